motor_arm_sequencer: RTL
========================

Name: motor_arm_sequencer

Overview:
Controller that sequences the motor duty-cycle datapath between the offset summer and the PWM generator.
- Gates the summed offset behind an arm/disarm state machine and holds the ESC base duty during initialisation.
- Clamps and slew-limits duty changes, and ramps the motors down on disarm or failsafe.
- One instance per motor. All updates are paced by a control-rate tick.

Parameters:
BASE_DUTY, 8'h32, ESC idle duty (50%); floor while armed.
MAX_DUTY, 8'h64, maximum duty (100%).
SLEW_STEP, 8'h02, maximum duty change per tick.
CNT_W, 16, width of the tick counters.
ARM_TICKS, 16'd100, consecutive ticks arm_req must be held before arming.
INIT_TICKS, 16'd200, ticks BASE_DUTY is held before passing the mix through.

Ports:
clk  input  1  system clock; single clock domain.
rst  input  1  synchronous, active-high reset.
tick  input  1  one-cycle control-rate strobe; state and duty advance only on tick.
arm_req  input  1  pilot arm switch (level).
failsafe  input  1  receiver signal lost (level).
mix_in  input  8  total offset from the summer, unsigned.
duty_out  output  8  duty to the PWM generator, 8'h00..8'h64.
armed  output  1  high in ESC_INIT, ARMED and RAMP_DOWN.
fault  output  1  sticky: set on failsafe exit from ARMED or ESC_INIT.
state_out  output  3  current state encoding, for debug.

Behaviour:
- Reset: state=DISARMED, duty_out=8'h00, armed=0, fault=0, counters=0, arm_latch=0. Reset wins over tick.
- All outputs are registered. They change only in the cycle after a tick, except the reset values.
- Cycles without tick hold all state.
- arm_latch is the safety interlock.
  - Set when arm_req=0 is sampled on a tick in DISARMED.
  - Cleared on any entry to DISARMED.
  - Arming therefore always requires arm_req to go low and then high again.
- DISARMED (duty_out=0):
  - On a tick with arm_latch=1, arm_req=1 and failsafe=0, arm_cnt increments.
  - Otherwise arm_cnt clears to 0.
  - When arm_cnt reaches ARM_TICKS-1 on a qualifying tick: go to ESC_INIT, duty_out=BASE_DUTY, init_cnt=0.
- ESC_INIT (duty_out=BASE_DUTY):
  - failsafe=1 → DISARMED, duty=0, fault=1.
  - arm_req=0 → DISARMED, duty=0.
  - After INIT_TICKS ticks → ARMED.
  - Precedence: failsafe over arm_req over counter.
- ARMED:
  - target = clamp(mix_in, BASE_DUTY, MAX_DUTY).
  - If |target−duty| ≤ SLEW_STEP, duty=target; otherwise duty moves by SLEW_STEP toward target.
  - failsafe=1 → RAMP_DOWN, fault=1. arm_req=0 → RAMP_DOWN. The transition tick applies no mix update.
- RAMP_DOWN:
  - Each tick, duty = max(duty−SLEW_STEP, BASE_DUTY).
  - On the tick where duty is already BASE_DUTY: go to DISARMED, duty=0.
  - arm_req and mix_in are ignored in this state.
- fault clears only on a tick in DISARMED with arm_req=0 and failsafe=0.
- Arithmetic:
  - Compute in 9 bits so duty+SLEW_STEP cannot wrap.
  - mix_in above MAX_DUTY (e.g. 8'hFF, summer wrap) clamps to MAX_DUTY.
  - mix_in below BASE_DUTY clamps to BASE_DUTY.
- Simultaneous failsafe and arm_req drop: treated as failsafe.
- Reset mid-ramp: immediate return to reset values on the next clock.

Decomposition:
- Shared package (motor_ctrl_pkg) holds:
  - state encodings: DISARMED=3'd0, ESC_INIT=3'd1, ARMED=3'd2, RAMP_DOWN=3'd3;
  - the duty constants 8'h32 and 8'h64, reused by the summer and the PWM generator.
- One sub-module: duty_slew_limiter. It is combinational and computes next duty from (duty, target, step, floor, ceiling) with the 9-bit clamp.
- The FSM and counters stay in the top module.

Test Plan:
1. Params ARM_TICKS=4, INIT_TICKS=3. rst, then arm_req=0 for 1 tick, then arm_req=1 with tick every cycle → duty 0 for 4 ticks, then 8'h32 for 3 ticks, then ARMED; armed=1 from tick 4.
2. arm_req held high from reset with no low phase → never arms; duty stays 8'h00 for 50 ticks.
3. ARMED with duty=8'h32, mix_in=8'h40, SLEW_STEP=2 → duty 34,36,…,40 (hex) over 7 ticks, then holds 8'h40. Then mix_in=8'hFF → ramps to 8'h64 and stops.
4. ARMED at duty=8'h3A, failsafe=1 → fault=1, duty 38,36,34,32 (hex), then 8'h00 in DISARMED. Re-arm is blocked until arm_req cycles low.
5. ESC_INIT with arm_req dropped at init tick 1 → next tick duty=8'h00, armed=0, fault=0. No tick pulses for 10 cycles → outputs unchanged.
6. rst asserted mid RAMP_DOWN (duty=8'h50) → next clock duty=8'h00, armed=0, fault=0, state_out=0.

Source files
------------

// File: rtl/motor_ctrl_pkg.sv
// Shared motor control definitions.
// State encodings and duty constants used across the motor datapath.
package motor_ctrl_pkg;

   typedef enum logic [2:0] {
      DISARMED  = 3'd0,
      ESC_INIT  = 3'd1,
      ARMED     = 3'd2,
      RAMP_DOWN = 3'd3
   } state_t;

   localparam logic [7:0] DUTY_BASE = 8'h32;
   localparam logic [7:0] DUTY_MAX  = 8'h64;
   localparam logic [7:0] DUTY_OFF  = 8'h00;

endpackage

// File: rtl/duty_slew_limiter.sv
// Combinational duty slew limiter.
// Clamps the target into [floor, ceiling] and steps duty toward it.
module duty_slew_limiter (
   input  logic [7:0] duty,
   input  logic [7:0] target,
   input  logic [7:0] step,
   input  logic [7:0] floor,
   input  logic [7:0] ceiling,
   output logic [7:0] duty_next
);

   logic [8:0] d9;
   logic [8:0] t9;
   logic [8:0] s9;
   logic [8:0] n9;
   logic       unused_msb;

   // clamp target, then move at most one step toward it in 9 bits
   always_comb begin
      t9 = {1'b0, target};
      if (t9 < {1'b0, floor}) begin
         t9 = {1'b0, floor};
      end else if (t9 > {1'b0, ceiling}) begin
         t9 = {1'b0, ceiling};
      end
      d9 = {1'b0, duty};
      s9 = {1'b0, step};
      n9 = t9;
      if ((t9 > d9) && ((t9 - d9) > s9)) begin
         n9 = d9 + s9;
      end else if ((d9 > t9) && ((d9 - t9) > s9)) begin
         n9 = d9 - s9;
      end
      duty_next  = n9[7:0];
      unused_msb = n9[8];
   end

endmodule

// File: rtl/motor_arm_sequencer.sv
// Per-motor arm/disarm sequencer between offset summer and PWM.
// Gates the mix behind arming, holds ESC idle, slews and ramps down.
module motor_arm_sequencer
   import motor_ctrl_pkg::*;
#(
   parameter logic [7:0]       BASE_DUTY  = DUTY_BASE,
   parameter logic [7:0]       MAX_DUTY   = DUTY_MAX,
   parameter logic [7:0]       SLEW_STEP  = 8'h02,
   parameter int               CNT_W      = 16,
   parameter logic [CNT_W-1:0] ARM_TICKS  = 16'd100,
   parameter logic [CNT_W-1:0] INIT_TICKS = 16'd200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       arm_req,
   input  logic       failsafe,
   input  logic [7:0] mix_in,
   output logic [7:0] duty_out,
   output logic       armed,
   output logic       fault,
   output logic [2:0] state_out
);

   localparam logic [CNT_W-1:0] ARM_LAST  = ARM_TICKS - 1'b1;
   localparam logic [CNT_W-1:0] INIT_LAST = INIT_TICKS - 1'b1;

   state_t           state;
   logic [7:0]       duty;
   logic [CNT_W-1:0] arm_cnt;
   logic [CNT_W-1:0] init_cnt;
   logic             arm_latch;
   logic [7:0]       target;
   logic [7:0]       duty_next;

   // ramp-down heads for the floor; otherwise follow the mix
   assign target = (state == RAMP_DOWN) ? BASE_DUTY : mix_in;

   duty_slew_limiter u_slew (
      .duty      (duty),
      .target    (target),
      .step      (SLEW_STEP),
      .floor     (BASE_DUTY),
      .ceiling   (MAX_DUTY),
      .duty_next (duty_next)
   );

   assign duty_out  = duty;
   assign state_out = state;

   // arming state machine, counters and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= DISARMED;
         duty      <= DUTY_OFF;
         armed     <= 1'b0;
         fault     <= 1'b0;
         arm_cnt   <= '0;
         init_cnt  <= '0;
         arm_latch <= 1'b0;
      end else if (tick) begin
         unique case (state)
            DISARMED: begin
               if (!arm_req) begin
                  arm_latch <= 1'b1;
               end
               if (!arm_req && !failsafe) begin
                  fault <= 1'b0;
               end
               if (arm_latch && arm_req && !failsafe) begin
                  if (arm_cnt == ARM_LAST) begin
                     state    <= ESC_INIT;
                     duty     <= BASE_DUTY;
                     armed    <= 1'b1;
                     init_cnt <= '0;
                     arm_cnt  <= '0;
                  end else begin
                     arm_cnt <= arm_cnt + 1'b1;
                  end
               end else begin
                  arm_cnt <= '0;
               end
            end
            ESC_INIT: begin
               if (failsafe || !arm_req) begin
                  state     <= DISARMED;
                  duty      <= DUTY_OFF;
                  armed     <= 1'b0;
                  arm_latch <= 1'b0;
                  arm_cnt   <= '0;
                  init_cnt  <= '0;
                  if (failsafe) begin
                     fault <= 1'b1;
                  end
               end else if (init_cnt == INIT_LAST) begin
                  state    <= ARMED;
                  init_cnt <= '0;
               end else begin
                  init_cnt <= init_cnt + 1'b1;
               end
            end
            ARMED: begin
               if (failsafe) begin
                  state <= RAMP_DOWN;
                  fault <= 1'b1;
               end else if (!arm_req) begin
                  state <= RAMP_DOWN;
               end else begin
                  duty <= duty_next;
               end
            end
            RAMP_DOWN: begin
               if (duty == BASE_DUTY) begin
                  state     <= DISARMED;
                  duty      <= DUTY_OFF;
                  armed     <= 1'b0;
                  arm_latch <= 1'b0;
                  arm_cnt   <= '0;
                  init_cnt  <= '0;
               end else begin
                  duty <= duty_next;
               end
            end
            default: begin
               state     <= DISARMED;
               duty      <= DUTY_OFF;
               armed     <= 1'b0;
               arm_latch <= 1'b0;
               arm_cnt   <= '0;
               init_cnt  <= '0;
            end
         endcase
      end
   end

endmodule
